// File: rtl/simple_mmap_axil_master.sv
// AXI4-Lite initiator: turns one local register command into a single AXI-Lite
// read or write and returns one response pulse. One transaction in flight.
module simple_mmap_axil_master #(
    parameter int unsigned C_M00_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_M00_AXI_DATA_WIDTH = 32
) (
    input  logic                                m00_axi_aclk,
    input  logic                                m00_axi_aresetn,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                                rsp_valid,
    output logic                                rsp_write,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic                                m00_axi_awvalid,
    input  logic                                m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                                m00_axi_wvalid,
    input  logic                                m00_axi_wready,
    input  logic [1:0]                          m00_axi_bresp,
    input  logic                                m00_axi_bvalid,
    output logic                                m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic                                m00_axi_arvalid,
    input  logic                                m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                          m00_axi_rresp,
    input  logic                                m00_axi_rvalid,
    output logic                                m00_axi_rready
);

    localparam int unsigned AW = C_M00_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M00_AXI_DATA_WIDTH;
    localparam int unsigned SW = DW / 8;

    // Registers are 32-bit aligned; the two byte-offset bits are always cleared.
    localparam logic [AW-1:0] ADDR_MASK = ~(AW'(3));

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_WAIT_B = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_WAIT_R = 3'd4;

    logic [2:0]    state_q,     state_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic [SW-1:0] wstrb_q,     wstrb_d;
    logic          awvalid_q,   awvalid_d;
    logic          wvalid_q,    wvalid_d;
    logic          bready_q,    bready_d;
    logic          arvalid_q,   arvalid_d;
    logic          rready_q,    rready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_write_q, rsp_write_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_resp_q,  rsp_resp_d;

    // State and output registers; reset lands in IDLE with only cmd_ready set.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d = cmd_addr & ADDR_MASK;
                    if (cmd_write) begin
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_READ;
                    end
                end
            end
            S_WRITE: begin
                // AW and W complete independently, in any order.
                awvalid_d = awvalid_q && !m00_axi_awready;
                wvalid_d  = wvalid_q && !m00_axi_wready;
                if ((!awvalid_q || m00_axi_awready) && (!wvalid_q || m00_axi_wready)) begin
                    bready_d = 1'b1;
                    state_d  = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (m00_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m00_axi_bresp;
                    state_d     = S_IDLE;
                end
            end
            S_READ: begin
                if (m00_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (m00_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m00_axi_rdata;
                    rsp_resp_d  = m00_axi_rresp;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_write       = rsp_write_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_resp        = rsp_resp_q;
    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = wstrb_q;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;

endmodule

// File: tb/tb_simple_mmap_axil_master.sv
// Bench for simple_mmap_axil_master: a cycle-stepped AXI-Lite slave with
// programmable wait states, and a register-bank model of expected results.
module tb_simple_mmap_axil_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] slv_mem   [4];
    logic [31:0] model_mem [4];

    simple_mmap_axil_master #(
        .C_M00_AXI_ADDR_WIDTH(4),
        .C_M00_AXI_DATA_WIDTH(32)
    ) dut (
        .m00_axi_aclk   (clk),
        .m00_axi_aresetn(rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .cmd_wstrb      (cmd_wstrb),
        .rsp_valid      (rsp_valid),
        .rsp_write      (rsp_write),
        .rsp_rdata      (rsp_rdata),
        .rsp_resp       (rsp_resp),
        .m00_axi_awaddr (awaddr),
        .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready),
        .m00_axi_wdata  (wdata),
        .m00_axi_wstrb  (wstrb),
        .m00_axi_wvalid (wvalid),
        .m00_axi_wready (wready),
        .m00_axi_bresp  (bresp),
        .m00_axi_bvalid (bvalid),
        .m00_axi_bready (bready),
        .m00_axi_araddr (araddr),
        .m00_axi_arvalid(arvalid),
        .m00_axi_arready(arready),
        .m00_axi_rdata  (rdata),
        .m00_axi_rresp  (rresp),
        .m00_axi_rvalid (rvalid),
        .m00_axi_rready (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    // One transaction against the stepped slave. Delays count cycles of valid
    // before ready (AW/W/AR) and cycles before the slave raises bvalid/rvalid.
    task automatic do_txn(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int aw_dly, input int w_dly,
                          input int ar_dly, input int br_dly, input logic [1:0] resp,
                          input logic pre_acc, input logic chain, input logic nx_wr,
                          input logic [3:0] nx_addr, input logic [31:0] nx_wd,
                          input logic [3:0] nx_ws);
        int aw_left = aw_dly, w_left = w_dly, ar_left = ar_dly, br_left = br_dly;
        int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0, rsp_n = 0;
        int rsp_cyc = 0, cyc = 0, proto = 0, exp_lat, hs_tag, exp_tag;
        logic        resp_sent = 1'b0, drop_resp = 1'b0;
        logic [3:0]  got_awaddr = 4'h0, got_araddr = 4'h0, got_wstrb = 4'h0, exp_a;
        logic [31:0] got_wdata = 32'h0, g_rdata = 32'h0, exp_rd;
        logic        g_write = 1'b0;
        logic [1:0]  g_resp = 2'b00;

        exp_a   = addr & 4'hC;
        exp_rd  = wr ? 32'h0 : model_mem[exp_a[3:2]];
        exp_lat = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + br_dly : 3 + ar_dly + br_dly;

        if (!pre_acc) begin
            @(negedge clk);
            cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1'b1;
            n_checks++;
            if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
            else n_pass++;
        end

        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) cmd_valid = 1'b0;

            // Protocol observations, using handshakes completed at earlier edges.
            if (wr) begin
                if (aw_n == 0 && !awvalid) proto++;
                if (aw_n > 0 && awvalid) proto++;
                if (w_n == 0 && !wvalid) proto++;
                if (w_n > 0 && wvalid) proto++;
                if (awvalid && awaddr !== exp_a) proto++;
                if (wvalid && (wdata !== wd || wstrb !== ws)) proto++;
                if (arvalid || rready) proto++;
                if (bready !== (aw_n == 1 && w_n == 1 && b_n == 0)) proto++;
            end else begin
                if (ar_n == 0 && !arvalid) proto++;
                if (ar_n > 0 && arvalid) proto++;
                if (arvalid && araddr !== exp_a) proto++;
                if (awvalid || wvalid || bready) proto++;
                if (rready !== (ar_n == 1 && r_n == 0)) proto++;
            end
            if (!rsp_valid && cmd_ready && rsp_n == 0) proto++;

            // Response channel of the slave.
            if (drop_resp) begin bvalid = 1'b0; rvalid = 1'b0; drop_resp = 1'b0; end
            if (!resp_sent && ((wr && aw_n == 1 && w_n == 1) || (!wr && ar_n == 1))) begin
                if (br_left == 0) begin
                    resp_sent = 1'b1;
                    if (wr) begin
                        bvalid = 1'b1; bresp = resp;
                        if (resp == 2'b00)
                            slv_mem[got_awaddr[3:2]] = merge(slv_mem[got_awaddr[3:2]], got_wdata, got_wstrb);
                    end else begin
                        rvalid = 1'b1; rresp = resp; rdata = slv_mem[got_araddr[3:2]];
                    end
                end else br_left--;
            end
            if (bvalid && bready) begin b_n++; drop_resp = 1'b1; end
            if (rvalid && rready) begin r_n++; drop_resp = 1'b1; end

            // Address/data channels of the slave.
            if (awvalid) begin
                if (aw_left == 0) awready = 1'b1; else begin awready = 1'b0; aw_left--; end
            end else awready = 1'b0;
            if (wvalid) begin
                if (w_left == 0) wready = 1'b1; else begin wready = 1'b0; w_left--; end
            end else wready = 1'b0;
            if (arvalid) begin
                if (ar_left == 0) arready = 1'b1; else begin arready = 1'b0; ar_left--; end
            end else arready = 1'b0;
            if (awvalid && awready) begin aw_n++; got_awaddr = awaddr; end
            if (wvalid && wready) begin w_n++; got_wdata = wdata; got_wstrb = wstrb; end
            if (arvalid && arready) begin ar_n++; got_araddr = araddr; end

            if (rsp_valid) begin
                rsp_n++;
                if (rsp_n == 1) begin
                    rsp_cyc = cyc; g_write = rsp_write; g_rdata = rsp_rdata; g_resp = rsp_resp;
                    if (chain) begin
                        cmd_write = nx_wr; cmd_addr = nx_addr; cmd_wdata = nx_wd;
                        cmd_wstrb = nx_ws; cmd_valid = 1'b1;
                        n_checks++;
                        if (cmd_ready !== 1'b1)
                            $display("FAIL cmd_ready_in_rsp_cycle: got %b expected 1", cmd_ready);
                        else n_pass++;
                        break;
                    end
                end
            end
            if (rsp_n > 0 && cyc == rsp_cyc + 1) break;
        end
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;

        n_checks++;
        if (rsp_n == 0) $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", cyc);
        else n_pass++;
        n_checks++;
        if (rsp_n != 1) $display("FAIL rsp_pulse_count: got %0d expected 1", rsp_n); else n_pass++;
        n_checks++;
        if (rsp_cyc != exp_lat) $display("FAIL rsp_latency: got %0d expected %0d", rsp_cyc, exp_lat);
        else n_pass++;
        n_checks++;
        if (g_write !== wr) $display("FAIL rsp_write: got %b expected %b", g_write, wr); else n_pass++;
        n_checks++;
        if (g_rdata !== exp_rd) $display("FAIL rsp_rdata: got %h expected %h", g_rdata, exp_rd);
        else n_pass++;
        n_checks++;
        if (g_resp !== resp) $display("FAIL rsp_resp: got %0d expected %0d", g_resp, resp); else n_pass++;
        n_checks++;
        if ((wr ? got_awaddr : got_araddr) !== exp_a)
            $display("FAIL axi_addr: got %h expected %h", wr ? got_awaddr : got_araddr, exp_a);
        else n_pass++;
        if (wr) begin
            n_checks++;
            if (got_wdata !== wd || got_wstrb !== ws)
                $display("FAIL axi_wdata: got %h/%h expected %h/%h", got_wdata, got_wstrb, wd, ws);
            else n_pass++;
        end
        hs_tag  = wr ? aw_n * 100 + w_n * 10 + b_n : ar_n * 10 + r_n;
        exp_tag = wr ? 111 : 11;
        n_checks++;
        if (hs_tag != exp_tag) $display("FAIL handshake_counts: got %0d expected %0d", hs_tag, exp_tag);
        else n_pass++;
        n_checks++;
        if (proto != 0) $display("FAIL axi_protocol: got %0d violations expected 0", proto); else n_pass++;

        if (wr && resp == 2'b00) model_mem[exp_a[3:2]] = merge(model_mem[exp_a[3:2]], wd, ws);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0)
            $display("FAIL reset_valids: got %b expected 000000",
                     {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
        else n_pass++;
        n_checks++;
        if ({awaddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_write} !== 75'b0)
            $display("FAIL reset_data: got %h expected 0", {awaddr, wdata, wstrb, rsp_rdata, rsp_resp, rsp_write});
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write_basic();
        do_txn(1'b1, 4'h4, 32'h12345678, 4'hF, 0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic test_read_wait();
        do_txn(1'b0, 4'h8, 32'h0, 4'h0, 0, 0, 0, 2, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic test_aw_before_w();
        do_txn(1'b1, 4'hC, 32'hCAFEF00D, 4'h5, 0, 3, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic test_unaligned_slverr();
        do_txn(1'b1, 4'h7, 32'hDEADBEEF, 4'hF, 1, 0, 0, 1, 2'b10, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        do_txn(1'b0, 4'h5, 32'h0, 4'h0, 0, 0, 1, 0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        do_txn(1'b1, 4'h0, 32'hA5A55A5A, 4'hF, 0, 0, 0, 0, 2'b00, 1'b0, 1'b1, 1'b0, 4'h2, 32'h0, 4'h0);
        do_txn(1'b0, 4'h2, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            logic       wr;
            logic [1:0] rs;
            wr = 1'($urandom % 2);
            rs = ($urandom % 4 == 0) ? 2'($urandom % 4) : 2'b00;
            do_txn(wr, 4'($urandom % 16), $urandom, 4'($urandom % 16), int'($urandom % 4),
                   int'($urandom % 4), int'($urandom % 4), int'($urandom % 4), rs,
                   1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
        end
    endtask

    task automatic test_reset_in_wait_r();
        int seen_rsp = 0;
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 4'h8; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        n_checks++;
        if (rready !== 1'b1) $display("FAIL wait_r_rready: got %b expected 1", rready); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0)
            $display("FAIL reset_mid_valids: got %b expected 000000",
                     {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp++;
        end
        n_checks++;
        if (seen_rsp != 0) $display("FAIL reset_mid_rsp: got %0d pulses expected 0", seen_rsp);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_mid_cmd_ready: got %b expected 1", cmd_ready);
        else n_pass++;
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            slv_mem[i]   = 32'h11111111 * i;
            model_mem[i] = 32'h11111111 * i;
        end
        slv_mem[2]   = 32'hEDCBA987;
        model_mem[2] = 32'hEDCBA987;

        test_reset();
        test_write_basic();
        test_read_wait();
        test_aw_before_w();
        test_unaligned_slverr();
        test_back_to_back();
        test_random();
        test_reset_in_wait_r();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
